// File: rtl/i2c_reg_target.sv
`timescale 1ns/1ps
// I2C target: 7-bit address, pointer byte, auto-incrementing register writes/reads. SCL/SDA seen SYNC_STAGES+1 clk late.
// No clock stretching, bus_wr is an unthrottled pulse. `I2C_GENERAL_CALL_EN enables general-call (0x00, 0x06) register clear.
module i2c_reg_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [AW-1:0] loc_addr,
  output logic [7:0]    loc_rdata,
  output logic          bus_wr,
  output logic [AW-1:0] bus_wr_addr,
  output logic [7:0]    bus_wr_data,
  output logic          busy
);

`ifdef I2C_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t        state, state_nx;
  logic [3:0]    bit_cnt, bit_cnt_nx;
  logic [6:0]    shreg, shreg_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic          sda_oe_nx, busy_nx;
  logic          gc, gc_nx;
  logic          wr_en, clr_regs, byte_done;
  logic [7:0]    rx_byte;
  logic [2:0]    tx_idx;
  logic [7:0]    regfile [NUM_REGS];

  // Idle bus is high on both lines, so the synchronizers reset to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign loc_rdata = regfile[loc_addr];

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    ptr_nx     = ptr;
    sda_oe_nx  = sda_oe;
    busy_nx    = busy;
    gc_nx      = gc;
    wr_en      = 1'b0;
    clr_regs   = 1'b0;
    rx_byte    = {shreg, sda_s};
    tx_idx     = 3'd7 - bit_cnt[2:0];
    byte_done  = scl_rise && (bit_cnt == 4'd7);
    if (stop_det) begin
      state_nx  = IDLE;
      sda_oe_nx = 1'b0;
      busy_nx   = 1'b0;
      gc_nx     = 1'b0;
    end else if (start_det) begin
      state_nx   = ADDR;
      bit_cnt_nx = '0;
      sda_oe_nx  = 1'b0;
      gc_nx      = 1'b0;
    end else begin
      if (scl_rise && (state == ADDR || state == PTR || state == WDATA)) begin
        shreg_nx   = rx_byte[6:0];
        bit_cnt_nx = bit_cnt + 4'd1;
      end
      case (state)
        ADDR: if (byte_done) begin
          bit_cnt_nx = '0;
          if (rx_byte[7:1] == SLAVE_ADDR || (GC_EN && rx_byte == 8'h00)) begin
            state_nx = ADDR_ACK;
            busy_nx  = 1'b1;
            gc_nx    = GC_EN && (rx_byte == 8'h00);
          end else begin
            state_nx = WAIT_STOP;
            busy_nx  = 1'b0;
          end
        end
        PTR: if (byte_done) begin
          bit_cnt_nx = '0;
          state_nx   = PTR_ACK;
          if (!gc) begin
            ptr_nx = rx_byte[AW-1:0];
          end else if (rx_byte == 8'h06) begin
            clr_regs = 1'b1;
            ptr_nx   = '0;
          end
        end
        WDATA: if (byte_done) begin
          bit_cnt_nx = '0;
          state_nx   = WDATA_ACK;
          if (!gc) begin
            wr_en  = 1'b1;
            ptr_nx = ptr + AW'(1);
          end
        end
        // First fall after the byte starts the ACK; the second ends it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_nx = 1'b1;
          end else begin
            bit_cnt_nx = '0;
            sda_oe_nx  = 1'b0;
            if (state == ADDR_ACK && shreg[0]) begin
              state_nx  = RDATA;
              sda_oe_nx = ~regfile[ptr][7];
            end else if (state == ADDR_ACK) begin
              state_nx = PTR;
            end else begin
              state_nx = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nx = 1'b0;
              state_nx  = RACK;
            end else begin
              sda_oe_nx = ~regfile[ptr][tx_idx];
            end
          end
        end
        RACK: if (scl_rise) begin
          if (!sda_s) begin
            ptr_nx     = ptr + AW'(1);
            bit_cnt_nx = '0;
            state_nx   = RDATA;
          end else begin
            state_nx = WAIT_STOP;
            busy_nx  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      ptr         <= '0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      gc          <= 1'b0;
      bus_wr      <= 1'b0;
      bus_wr_addr <= '0;
      bus_wr_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      ptr     <= ptr_nx;
      sda_oe  <= sda_oe_nx;
      busy    <= busy_nx;
      gc      <= gc_nx;
      bus_wr  <= wr_en;
      if (wr_en) begin
        bus_wr_addr  <= ptr;
        bus_wr_data  <= rx_byte;
        regfile[ptr] <= rx_byte;
      end
      if (clr_regs) begin
        for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
`timescale 1ns/1ps
// Directed bench for i2c_reg_target: bus-functional I2C master with open-drain SDA model.
module tb_i2c_reg_target;
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic       sda_line;
  logic       sda_oe;
  logic [3:0] loc_addr = '0;
  logic [7:0] loc_rdata;
  logic       bus_wr;
  logic [3:0] bus_wr_addr;
  logic [7:0] bus_wr_data;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;

  logic       mon_clr = 1'b1;
  logic       oe_seen = 1'b0;
  logic       busy_seen = 1'b0;
  int         wr_cnt = 0;
  logic [3:0] wr_a [0:7];
  logic [7:0] wr_d [0:7];

  always #5 clk = ~clk;
  assign sda_line = ~(m_sda_low | sda_oe);

  i2c_reg_target #(.SLAVE_ADDR(7'h50), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .scl_in(m_scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata), .bus_wr(bus_wr),
    .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data), .busy(busy)
  );

  always @(posedge clk) begin
    if (mon_clr) begin
      oe_seen   <= 1'b0;
      busy_seen <= 1'b0;
      wr_cnt    <= 0;
    end else begin
      if (sda_oe) oe_seen <= 1'b1;
      if (busy) busy_seen <= 1'b1;
      if (bus_wr) begin
        if (wr_cnt < 8) begin
          wr_a[wr_cnt] <= bus_wr_addr;
          wr_d[wr_cnt] <= bus_wr_data;
        end
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    loc_addr = a;
    @(negedge clk);
    check_eq(tag, loc_rdata, exp);
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic m_start();
    m_sda_low = 1'b1; #Q;
    m_scl = 1'b0;     #Q;
  endtask

  task automatic m_rstart();
    m_sda_low = 1'b0; #Q;
    m_scl = 1'b1;     #Q;
    m_sda_low = 1'b1; #Q;
    m_scl = 1'b0;     #Q;
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1; #Q;
    m_scl = 1'b1;     #Q;
    m_sda_low = 1'b0; #(2*Q);
  endtask

  task automatic m_send_bit(input logic b);
    m_sda_low = ~b; #Q;
    m_scl = 1'b1;   #(2*Q);
    m_scl = 1'b0;   #Q;
  endtask

  task automatic m_recv_bit(output logic b);
    m_sda_low = 1'b0; #Q;
    m_scl = 1'b1;     #Q;
    b = sda_line;     #Q;
    m_scl = 1'b0;     #Q;
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) m_send_bit(d[i]);
    m_recv_bit(b);
    ack = ~b;
  endtask

  task automatic m_read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      m_recv_bit(b);
      d = {d[6:0], b};
    end
    m_send_bit(~ack);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, run stopped");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_sda_oe", sda_oe, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_bus_wr", bus_wr, 1'b0);
    check_reg("rst_reg3", 4'd3, 8'h00);
    reset_n = 1'b1;
    mon_clear();
    repeat (4) @(negedge clk);

    // Write 0x5A, 0xC3 starting at register 3
    m_start();
    m_write_byte(8'hA0, ack); check_eq("w_addr_ack", ack, 1'b1);
    m_write_byte(8'h03, ack); check_eq("w_ptr_ack", ack, 1'b1);
    m_write_byte(8'h5A, ack); check_eq("w_d0_ack", ack, 1'b1);
    m_write_byte(8'hC3, ack); check_eq("w_d1_ack", ack, 1'b1);
    check_eq("w_busy", busy, 1'b1);
    m_stop();
    check_eq("w_busy_after_stop", busy, 1'b0);
    check_eq("w_wr_cnt", wr_cnt, 2);
    check_eq("w_wr0_addr", wr_a[0], 4'd3);
    check_eq("w_wr0_data", wr_d[0], 8'h5A);
    check_eq("w_wr1_addr", wr_a[1], 4'd4);
    check_eq("w_wr1_data", wr_d[1], 8'hC3);
    check_reg("w_reg4", 4'd4, 8'hC3);
    check_reg("w_reg3", 4'd3, 8'h5A);

    // Read back with repeated START
    m_start();
    m_write_byte(8'hA0, ack); check_eq("r_addr_ack", ack, 1'b1);
    m_write_byte(8'h03, ack); check_eq("r_ptr_ack", ack, 1'b1);
    m_rstart();
    m_write_byte(8'hA1, ack); check_eq("r_raddr_ack", ack, 1'b1);
    m_read_byte(d, 1'b1);     check_eq("r_byte0", d, 8'h5A);
    m_read_byte(d, 1'b0);     check_eq("r_byte1", d, 8'hC3);
    check_eq("r_oe_released", sda_oe, 1'b0);
    check_eq("r_busy_after_nack", busy, 1'b0);
    m_stop();
    check_eq("r_busy_after_stop", busy, 1'b0);

    // Pointer wrap 15 -> 0
    mon_clear();
    m_start();
    m_write_byte(8'hA0, ack); check_eq("wrap_addr_ack", ack, 1'b1);
    m_write_byte(8'h0F, ack); check_eq("wrap_ptr_ack", ack, 1'b1);
    m_write_byte(8'h11, ack); check_eq("wrap_d0_ack", ack, 1'b1);
    m_write_byte(8'h22, ack); check_eq("wrap_d1_ack", ack, 1'b1);
    m_stop();
    check_eq("wrap_wr_cnt", wr_cnt, 2);
    check_eq("wrap_wr0_addr", wr_a[0], 4'd15);
    check_eq("wrap_wr1_addr", wr_a[1], 4'd0);
    check_reg("wrap_reg15", 4'd15, 8'h11);
    check_reg("wrap_reg0", 4'd0, 8'h22);

    // Address mismatch
    mon_clear();
    m_start();
    m_write_byte(8'hA2, ack); check_eq("mm_addr_nack", ack, 1'b0);
    m_write_byte(8'h00, ack); check_eq("mm_data_nack", ack, 1'b0);
    m_stop();
    check_eq("mm_oe_seen", oe_seen, 1'b0);
    check_eq("mm_busy_seen", busy_seen, 1'b0);
    check_eq("mm_wr_cnt", wr_cnt, 0);
    check_reg("mm_reg3", 4'd3, 8'h5A);

    // Reset in the middle of a read while the target pulls SDA low
    m_start();
    m_write_byte(8'hA0, ack); check_eq("mr_addr_ack", ack, 1'b1);
    m_write_byte(8'h03, ack); check_eq("mr_ptr_ack", ack, 1'b1);
    m_rstart();
    m_write_byte(8'hA1, ack); check_eq("mr_raddr_ack", ack, 1'b1);
    check_eq("mr_oe_driving", sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("mr_oe_async_release", sda_oe, 1'b0);
    check_eq("mr_busy_cleared", busy, 1'b0);
    check_reg("mr_reg3_cleared", 4'd3, 8'h00);
    check_reg("mr_reg15_cleared", 4'd15, 8'h00);
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    mon_clear();
    repeat (4) @(negedge clk);
    m_start();
    m_write_byte(8'hA0, ack); check_eq("pr_addr_ack", ack, 1'b1);
    m_write_byte(8'h07, ack); check_eq("pr_ptr_ack", ack, 1'b1);
    m_write_byte(8'h77, ack); check_eq("pr_d0_ack", ack, 1'b1);
    m_stop();
    check_eq("pr_wr_cnt", wr_cnt, 1);
    check_eq("pr_wr0_addr", wr_a[0], 4'd7);
    check_eq("pr_wr0_data", wr_d[0], 8'h77);
    check_reg("pr_reg7", 4'd7, 8'h77);

    // General call
    mon_clear();
    m_start();
`ifdef I2C_GENERAL_CALL_EN
    m_write_byte(8'h00, ack); check_eq("gc_addr_ack", ack, 1'b1);
    m_write_byte(8'h06, ack); check_eq("gc_cmd_ack", ack, 1'b1);
    m_stop();
    check_eq("gc_wr_cnt", wr_cnt, 0);
    check_reg("gc_reg7_cleared", 4'd7, 8'h00);
`else
    m_write_byte(8'h00, ack); check_eq("gc_off_nack", ack, 1'b0);
    m_stop();
    check_eq("gc_off_busy_seen", busy_seen, 1'b0);
    check_reg("gc_off_reg7", 4'd7, 8'h77);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
